// File: rtl/ysyx_25030093_pkg.sv
// rtl/ysyx_25030093_pkg.sv - shared MEMU state encoding, in_op bit positions and access sizes
package ysyx_25030093_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_RSP = 2'd2,
    ST_DONE     = 2'd3
  } memu_state_t;

  // in_op layout: [3] store, [2] unsigned load, [1:0] access size
  localparam int OP_STORE_BIT    = 3;
  localparam int OP_UNSIGNED_BIT = 2;
  localparam int OP_SIZE_MSB     = 1;
  localparam int OP_SIZE_LSB     = 0;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_D = 2'b11;

  // A double access on a 32-bit datapath degrades to a word access
  function automatic logic [1:0] eff_size(input logic [1:0] size, input logic has_double);
    return ((size == SIZE_D) && !has_double) ? SIZE_W : size;
  endfunction

endpackage

// File: rtl/ysyx_25030093_memu_align.sv
// rtl/ysyx_25030093_memu_align.sv - byte-lane placement for stores and lane extract/extend for loads
module ysyx_25030093_memu_align
  import ysyx_25030093_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NB    = XLEN / 8,
  parameter int OFF_W = $clog2(XLEN / 8)
) (
  input  logic [1:0]       size,
  input  logic             is_unsigned,
  input  logic [OFF_W-1:0] off,
  input  logic [XLEN-1:0]  st_data,
  input  logic [XLEN-1:0]  rdata,
  output logic [NB-1:0]    wmask,
  output logic [XLEN-1:0]  wdata,
  output logic [XLEN-1:0]  ldata
);

  logic [NB-1:0]     base_mask;
  logic [XLEN-1:0]   shifted;
  logic [XLEN-1:0]   keep;
  logic              msb;
  logic [OFF_W+2:0]  shamt;

  assign shamt = {off, 3'b000};

  // Store side: size mask and data moved up to the addressed lane; lanes past the bus fall off
  always_comb begin
    base_mask = '0;
    case (size)
      SIZE_B:  base_mask = NB'(1);
      SIZE_H:  base_mask = NB'(3);
      SIZE_W:  base_mask = NB'(4'hF);
      default: base_mask = '1;
    endcase
    wmask = base_mask << off;
    wdata = st_data << shamt;
  end

  // Load side: bring the addressed lane down to bit 0, then keep the access width and extend
  always_comb begin
    shifted = rdata >> shamt;
    keep    = '1;
    msb     = shifted[XLEN-1];
    case (size)
      SIZE_B: begin
        keep = XLEN'(8'hFF);
        msb  = shifted[7];
      end
      SIZE_H: begin
        keep = XLEN'(16'hFFFF);
        msb  = shifted[15];
      end
      SIZE_W: begin
        keep = XLEN'(32'hFFFF_FFFF);
        msb  = shifted[31];
      end
      default: begin
        keep = '1;
        msb  = shifted[XLEN-1];
      end
    endcase
    ldata = (is_unsigned || !msb) ? (shifted & keep) : (shifted | ~keep);
  end

endmodule

// File: rtl/ysyx_25030093_memu.sv
// rtl/ysyx_25030093_memu.sv - memory-access unit FSM (optional misalign trap: YSYX_25030093_MISALIGN_CHK_EN)
module ysyx_25030093_memu
  import ysyx_25030093_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_mem_en,
  input  logic [3:0]          in_op,
  input  logic [XLEN-1:0]     in_addr,
  input  logic [XLEN-1:0]     in_wdata,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_data,
  output logic                out_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_wen,
  output logic [XLEN-1:0]     mem_req_wdata,
  output logic [XLEN/8-1:0]   mem_req_wmask,
  input  logic                mem_rsp_valid,
  input  logic [XLEN-1:0]     mem_rsp_rdata
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  memu_state_t       state;
  logic              accept;
  logic [1:0]        in_size;
  logic [OFF_W-1:0]  in_off;

  // Transaction context held from accept until the result leaves
  logic [1:0]        cap_size;
  logic              cap_store;
  logic              cap_unsigned;
  logic [OFF_W-1:0]  cap_off;

  logic [1:0]        al_size;
  logic [OFF_W-1:0]  al_off;
  logic [NB-1:0]     al_wmask;
  logic [XLEN-1:0]   al_wdata;
  logic [XLEN-1:0]   al_ldata;

  assign in_ready = (state == ST_IDLE);
  assign accept   = in_valid && in_ready;
  assign in_size  = eff_size(in_op[OP_SIZE_MSB:OP_SIZE_LSB], XLEN == 64);
  assign in_off   = in_addr[OFF_W-1:0];

  // In IDLE the aligner sees the incoming request (store lanes); afterwards the captured one (load extract)
  assign al_size = in_ready ? in_size : cap_size;
  assign al_off  = in_ready ? in_off  : cap_off;

  ysyx_25030093_memu_align #(
    .XLEN  (XLEN),
    .NB    (NB),
    .OFF_W (OFF_W)
  ) u_align (
    .size        (al_size),
    .is_unsigned (cap_unsigned),
    .off         (al_off),
    .st_data     (in_wdata),
    .rdata       (mem_rsp_rdata),
    .wmask       (al_wmask),
    .wdata       (al_wdata),
    .ldata       (al_ldata)
  );

`ifdef YSYX_25030093_MISALIGN_CHK_EN
  logic misaligned;
  logic out_err_q;

  assign out_err = out_err_q;

  // Natural-alignment test on the incoming request
  always_comb begin
    misaligned = 1'b0;
    case (in_size)
      SIZE_H:  misaligned = in_off[0];
      SIZE_W:  misaligned = |in_off[1:0];
      SIZE_D:  misaligned = |in_off;
      default: misaligned = 1'b0;
    endcase
  end
`else
  assign out_err = 1'b0;
`endif

  // Request/response sequencing with all bus and result outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      cap_size      <= SIZE_B;
      cap_store     <= 1'b0;
      cap_unsigned  <= 1'b0;
      cap_off       <= '0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wen   <= 1'b0;
      mem_req_wdata <= '0;
      mem_req_wmask <= '0;
      out_valid     <= 1'b0;
      out_data      <= '0;
`ifdef YSYX_25030093_MISALIGN_CHK_EN
      out_err_q     <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cap_size     <= in_size;
            cap_store    <= in_op[OP_STORE_BIT];
            cap_unsigned <= in_op[OP_UNSIGNED_BIT];
            cap_off      <= in_off;
`ifdef YSYX_25030093_MISALIGN_CHK_EN
            out_err_q    <= 1'b0;
`endif
            if (!in_mem_en) begin
              out_data  <= in_addr;
              out_valid <= 1'b1;
              state     <= ST_DONE;
            end
`ifdef YSYX_25030093_MISALIGN_CHK_EN
            else if (misaligned) begin
              out_data  <= '0;
              out_err_q <= 1'b1;
              out_valid <= 1'b1;
              state     <= ST_DONE;
            end
`endif
            else begin
              mem_req_valid <= 1'b1;
              mem_req_addr  <= in_addr[ADDR_W-1:0];
              mem_req_wen   <= in_op[OP_STORE_BIT];
              mem_req_wdata <= al_wdata;
              mem_req_wmask <= al_wmask;
              state         <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= ST_WAIT_RSP;
          end
        end
        ST_WAIT_RSP: begin
          if (mem_rsp_valid) begin
            out_data  <= cap_store ? '0 : al_ldata;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25030093_memu.sv
// tb/tb_ysyx_25030093_memu.sv - directed self-checking bench for the MEMU
module tb_ysyx_25030093_memu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_mem_en;
  logic [3:0]  in_op;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_wen;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;

  int n_cmp = 0;
  int n_err = 0;

  ysyx_25030093_memu #(.XLEN(32), .ADDR_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_mem_en     (in_mem_en),
    .in_op         (in_op),
    .in_addr       (in_addr),
    .in_wdata      (in_wdata),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_err       (out_err),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wen   (mem_req_wen),
    .mem_req_wdata (mem_req_wdata),
    .mem_req_wmask (mem_req_wmask),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_rdata (mem_rsp_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One accept cycle, then scramble the inputs to prove they were captured
  task automatic issue(input logic mem_en, input logic [3:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata);
    in_valid  = 1'b1;
    in_mem_en = mem_en;
    in_op     = op;
    in_addr   = addr;
    in_wdata  = wdata;
    tick();
    in_valid  = 1'b0;
    in_mem_en = 1'b0;
    in_op     = 4'hF;
    in_addr   = 32'hDEAD_BEEF;
    in_wdata  = 32'h5A5A_5A5A;
  endtask

  task automatic finish_result(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_idle_ready"}, in_ready, 1'b1);
    check({tag, "_idle_ovalid"}, out_valid, 1'b0);
  endtask

  // Full load transaction with immediate handshakes
  task automatic do_load(input string tag, input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic [3:0] exp_mask,
                         input logic [31:0] exp_data);
    check({tag, "_pre_ready"}, in_ready, 1'b1);
    issue(1'b1, op, addr, 32'h0);
    check({tag, "_req_valid"}, mem_req_valid, 1'b1);
    check({tag, "_req_addr"}, mem_req_addr, addr);
    check({tag, "_req_wen"}, mem_req_wen, 1'b0);
    check({tag, "_req_wmask"}, mem_req_wmask, exp_mask);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check({tag, "_req_drop"}, mem_req_valid, 1'b0);
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = rdata;
    tick();
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = 32'h0;
    check({tag, "_out_valid"}, out_valid, 1'b1);
    check({tag, "_out_data"}, out_data, exp_data);
    check({tag, "_out_err"}, out_err, 1'b0);
    finish_result(tag);
  endtask

  initial begin
    rst           = 1'b1;
    in_valid      = 1'b0;
    in_mem_en     = 1'b0;
    in_op         = 4'h0;
    in_addr       = 32'h0;
    in_wdata      = 32'h0;
    out_ready     = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = 32'h0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_req_valid", mem_req_valid, 1'b0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_out_err", out_err, 1'b0);
    check("rst_wmask", mem_req_wmask, 4'h0);

    // Stray response while idle is ignored
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'h1111_2222;
    tick();
    mem_rsp_valid = 1'b0;
    check("idle_rsp_ovalid", out_valid, 1'b0);
    check("idle_rsp_ready", in_ready, 1'b1);

    // Pass-through: result one cycle after accept, no memory request
    check("pt_pre_ovalid", out_valid, 1'b0);
    issue(1'b0, 4'h2, 32'h0000_1234, 32'h0);
    check("pt_out_valid", out_valid, 1'b1);
    check("pt_out_data", out_data, 32'h0000_1234);
    check("pt_req_valid", mem_req_valid, 1'b0);
    check("pt_in_ready", in_ready, 1'b0);
    finish_result("pt");

    // Byte loads at the top lane, signed and unsigned
    do_load("lb",  4'b0000, 32'h0000_1003, 32'h80FF_FFFF, 4'h8, 32'hFFFF_FF80);
    do_load("lbu", 4'b0100, 32'h0000_1003, 32'h80FF_FFFF, 4'h8, 32'h0000_0080);
    // Halfword loads at the upper lane
    do_load("lh",  4'b0001, 32'h0000_1002, 32'hF0F0_1234, 4'hC, 32'hFFFF_F0F0);
    do_load("lhu", 4'b0101, 32'h0000_1002, 32'hF0F0_1234, 4'hC, 32'h0000_F0F0);
    // Double op on a 32-bit build behaves as a word
    do_load("ld32", 4'b0011, 32'h0000_1000, 32'h8765_4321, 4'hF, 32'h8765_4321);

    // Halfword store with a 3-cycle ack delay
    issue(1'b1, 4'b1001, 32'h0000_2002, 32'h0000_ABCD);
    check("sh_req_valid", mem_req_valid, 1'b1);
    check("sh_req_wen", mem_req_wen, 1'b1);
    check("sh_req_wmask", mem_req_wmask, 4'hC);
    check("sh_req_wdata_hi", mem_req_wdata[31:16], 16'hABCD);
    check("sh_req_addr", mem_req_addr, 32'h0000_2002);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("sh_wait_ovalid", out_valid, 1'b0);
      tick();
    end
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'hFFFF_FFFF;
    tick();
    mem_rsp_valid = 1'b0;
    check("sh_out_valid", out_valid, 1'b1);
    check("sh_out_data", out_data, 32'h0);
    finish_result("sh");

    // Backpressure on both request and result sides
    issue(1'b1, 4'b0010, 32'h0000_3000, 32'h0);
    for (int i = 0; i < 4; i++) begin
      check("bp_req_valid", mem_req_valid, 1'b1);
      check("bp_req_addr", mem_req_addr, 32'h0000_3000);
      check("bp_req_wmask", mem_req_wmask, 4'hF);
      check("bp_in_ready", in_ready, 1'b0);
      tick();
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check("bp_wait_in_ready", in_ready, 1'b0);
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'h1234_5678;
    tick();
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = 32'h0;
    for (int i = 0; i < 2; i++) begin
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_out_data", out_data, 32'h1234_5678);
      check("bp_out_in_ready", in_ready, 1'b0);
      tick();
    end
    finish_result("bp");

    // Reset while waiting for a response; the late response must be dropped
    issue(1'b1, 4'b0010, 32'h0000_4000, 32'h0);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rw_in_ready", in_ready, 1'b1);
    check("rw_req_valid", mem_req_valid, 1'b0);
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'hCAFE_F00D;
    tick();
    mem_rsp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("rw_out_valid", out_valid, 1'b0);
      check("rw_stay_idle", in_ready, 1'b1);
      tick();
    end

    // Misaligned word load
`ifdef YSYX_25030093_MISALIGN_CHK_EN
    issue(1'b1, 4'b0010, 32'h0000_1001, 32'h0);
    check("mis_req_valid", mem_req_valid, 1'b0);
    check("mis_out_valid", out_valid, 1'b1);
    check("mis_out_err", out_err, 1'b1);
    check("mis_out_data", out_data, 32'h0);
    finish_result("mis");
`else
    do_load("mis", 4'b0010, 32'h0000_1001, 32'hAABB_CCDD, 4'hE, 32'h00AA_BBCC);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_25030093_memu.md
YSYX_25030093_MEMU -- requirements
Module: ysyx_25030093_MEMU

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width; legal values 32 and 64.
REQ-002 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-003 SHALL have ports: clk input 1, sole clock; rst input 1, synchronous active-high reset.
REQ-004 SHALL have ports: in_valid input 1, upstream request valid; in_ready output 1, upstream may issue.
REQ-005 SHALL have ports: in_mem_en input 1, memory access required; in_op input 4, access op; in_addr input XLEN, address or pass-through value; in_wdata input XLEN, store data.
REQ-006 SHALL have ports: out_valid output 1, result valid; out_ready input 1, downstream accepts; out_data output XLEN, result; out_err output 1, misaligned-access flag.
REQ-007 SHALL have ports: mem_req_valid output 1; mem_req_ready input 1; mem_req_addr output ADDR_W; mem_req_wen output 1; mem_req_wdata output XLEN; mem_req_wmask output XLEN/8.
REQ-008 SHALL have ports: mem_rsp_valid input 1, response or write ack; mem_rsp_rdata input XLEN, read data.

Function
REQ-009 SHALL decode in_op as bit3 = store, bit2 = unsigned load, bits[1:0] = size (00 byte, 01 half, 10 word, 11 double); with XLEN=32, size 11 SHALL be treated as word.
REQ-010 SHALL implement states IDLE, REQ, WAIT_RSP, DONE; in_ready = (state == IDLE).
REQ-011 SHALL capture in_mem_en, in_op, in_addr, in_wdata on the in_valid && in_ready cycle; later input changes SHALL not affect the transaction.
REQ-012 IDLE: on accept with in_mem_en=0 -> DONE, out_data = captured in_addr (1-cycle latency); with in_mem_en=1 -> REQ; no accept -> stay IDLE.
REQ-013 REQ: mem_req_valid=1 with addr, wen, wdata, wmask stable; on mem_req_ready -> WAIT_RSP; otherwise hold.
REQ-014 WAIT_RSP: on mem_rsp_valid -> DONE, load result registered; mem_rsp_valid in any other state SHALL be ignored.
REQ-015 DONE: out_valid=1 with out_data/out_err stable; on out_ready -> IDLE; no back-to-back accept in the DONE cycle.
REQ-016 Lane offset off = in_addr[log2(XLEN/8)-1:0]; wmask = size mask (1, 3, 0xF, 0xFF) shifted left by off, bits beyond XLEN/8 dropped; wdata = store data replicated/shifted to lane off.
REQ-017 Load result = mem_rsp_rdata >> (8*off), truncated to size, then zero-extended if bit2=1, else sign-extended to XLEN.
REQ-018 Store result SHALL be out_data = 0; a store still waits for mem_rsp_valid as the write ack.
REQ-019 mem_req_addr = in_addr[ADDR_W-1:0] unmodified.

Reset
REQ-020 On rst: state IDLE, in_ready=1, out_valid=0, mem_req_valid=0, out_data=0, out_err=0, wmask=0.
REQ-021 rst in REQ/WAIT_RSP/DONE SHALL abandon the transaction with no output; a response arriving after reset SHALL be ignored.

Configuration
REQ-022 Macro YSYX_25030093_MISALIGN_CHK_EN: when defined, a half access with off[0]!=0, a word with off[1:0]!=0, or a double with off[2:0]!=0 SHALL skip REQ and go IDLE -> DONE with out_err=1, out_data=0.
REQ-023 Macro undefined: out_err tied 0; misaligned accesses are issued as in REQ-016, with lanes beyond XLEN/8 dropped.

Structure
REQ-024 Shared package ysyx_25030093_pkg SHALL hold the state enum, in_op bit positions, and size encodings.
REQ-025 One sub-module ysyx_25030093_MEMU_align (combinational wmask/wdata shift and load extract/extend) SHALL be instantiated; the FSM stays in the top module.

Verification
REQ-026 Pass-through: in_mem_en=0, in_addr=0x1234 -> out_valid exactly one cycle after accept, out_data=0x1234, no mem_req_valid.
REQ-027 LB signed: addr=0x1003, rdata=0x80FF_FF_FF -> wmask=0x8, out_data=0xFFFF_FF80; LBU with the same inputs -> 0x0000_0080.
REQ-028 SH: addr=0x2002, wdata=0xABCD -> wmask=0xC, wdata[31:16]=0xABCD; ack after 3 cycles -> out_data=0.
REQ-029 Backpressure: mem_req_ready low 4 cycles, out_ready low 2 cycles -> request and result held stable, in_ready=0 throughout.
REQ-030 Reset in WAIT_RSP, then mem_rsp_valid pulse -> stays IDLE, out_valid never asserted.
REQ-031 With MISALIGN_CHK_EN, LW addr=0x1001 -> no mem_req_valid, out_err=1 one cycle after accept; without it -> request issued with wmask=0xE.
